// File: rtl/bp_me_xui_pkg.sv
// Shared types for the XUI RAM responder: app command encodings and the
// write-pairing FSM state.
package bp_me_xui_pkg;

    typedef enum logic [2:0] {
        e_xui_cmd_wr = 3'b000,
        e_xui_cmd_rd = 3'b001
    } bp_xui_cmd_e;

    typedef enum logic [1:0] {
        e_xui_idle,
        e_xui_wait_data,
        e_xui_wait_cmd
    } bp_xui_state_e;

endpackage

// File: rtl/bp_me_xui_rd_pipe.sv
// Read-return pipeline: delays the read-issue strobe by rd_latency_p cycles
// and carries RAM output data alongside it, holding data between valids.
module bp_me_xui_rd_pipe #(
    parameter int width_p      = 512,
    parameter int rd_latency_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               rd_v_i,
    input  logic [width_p-1:0] ram_data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic [rd_latency_p-1:0] v_r;

    // v_r[0] lines up with the RAM's registered read data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r <= '0;
        end else begin
            v_r[0] <= rd_v_i;
            for (int i = 1; i < rd_latency_p; i++) begin
                v_r[i] <= v_r[i-1];
            end
        end
    end

    assign v_o = v_r[rd_latency_p-1];

    generate
        if (rd_latency_p == 1) begin : g_direct
            assign data_o = ram_data_i;
        end else begin : g_stages
            logic [width_p-1:0] d_r [rd_latency_p-1];

            // Each stage loads only when a valid passes, so the tail holds.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int i = 0; i < rd_latency_p-1; i++) begin
                        d_r[i] <= '0;
                    end
                end else begin
                    if (v_r[0]) begin
                        d_r[0] <= ram_data_i;
                    end
                    for (int i = 1; i < rd_latency_p-1; i++) begin
                        if (v_r[i]) begin
                            d_r[i] <= d_r[i-1];
                        end
                    end
                end
            end

            assign data_o = d_r[rd_latency_p-2];
        end
    endgenerate

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables (1 = write byte).
// Read data is registered and held until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int width_p = 512,
    parameter int els_p   = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic [$clog2(els_p)-1:0]   addr_i,
    input  logic                       v_i,
    input  logic [(width_p>>3)-1:0]    write_mask_i,
    input  logic                       w_i,
    output logic [width_p-1:0]         data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int b = 0; b < (width_p >> 3); b++) begin
                if (write_mask_i[b]) begin
                    mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (v_i & ~w_i) begin
            data_o <= mem_r[addr_i];
        end
    end

endmodule

// File: rtl/bp_me_xui_ram_responder.sv
// XUI/MIG app-port responder backed by a local byte-masked RAM.
// Optional macro BP_XUI_REFRESH_STALL_EN adds periodic refresh stalls on the readies.
module bp_me_xui_ram_responder
    import bp_me_xui_pkg::*;
#(
    parameter int paddr_width_p    = 32,
    parameter int block_width_p    = 512,
    parameter int els_p            = 1024,
    parameter int rd_latency_p     = 4,
    parameter int refresh_period_p = 512,
    parameter int refresh_len_p    = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [paddr_width_p-1:0]   app_addr_i,
    input  logic [2:0]                 app_cmd_i,
    input  logic                       app_en_i,
    output logic                       app_rdy_o,
    input  logic                       app_wdf_wren_i,
    input  logic [block_width_p-1:0]   app_wdf_data_i,
    input  logic [block_width_p/8-1:0] app_wdf_mask_i,
    input  logic                       app_wdf_end_i,
    output logic                       app_wdf_rdy_o,
    output logic                       app_rd_data_valid_o,
    output logic [block_width_p-1:0]   app_rd_data_o,
    output logic                       app_rd_data_end_o
);

    localparam int byte_offset_lp = $clog2(block_width_p/8);
    localparam int lg_els_lp      = $clog2(els_p);
    localparam int mask_width_lp  = block_width_p/8;

    bp_xui_state_e state_r, state_n;
    logic ready_en_r, stall;
    logic fsm_rdy, fsm_wdf_rdy;
    logic cmd_acc, data_acc, cmd_is_wr, cmd_is_rd;
    logic latch_addr, latch_data;
    logic [lg_els_lp-1:0]     cmd_idx, addr_r;
    logic [block_width_p-1:0] wdata_r;
    logic [mask_width_lp-1:0] wmask_r;

    logic                     ram_v, ram_w;
    logic [lg_els_lp-1:0]     ram_addr;
    logic [block_width_p-1:0] ram_wdata, ram_rdata;
    logic [mask_width_lp-1:0] ram_wmask;

    logic unused_inputs;
    assign unused_inputs = app_wdf_end_i ^ (^app_addr_i);

`ifdef BP_XUI_REFRESH_STALL_EN
    localparam int refresh_cnt_width_lp = $clog2(refresh_period_p);
    logic [refresh_cnt_width_lp-1:0] refresh_cnt_r;

    // Free-running refresh phase; the first refresh_len_p counts stall.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            refresh_cnt_r <= '0;
        end else if (refresh_cnt_r == refresh_cnt_width_lp'(refresh_period_p-1)) begin
            refresh_cnt_r <= '0;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + refresh_cnt_width_lp'(1);
        end
    end

    assign stall = (refresh_cnt_r < refresh_cnt_width_lp'(refresh_len_p));
`else
    localparam int unused_refresh_lp = refresh_period_p + refresh_len_p;
    assign stall = 1'b0;
`endif

    assign cmd_idx     = app_addr_i[byte_offset_lp +: lg_els_lp];
    assign fsm_rdy     = (state_r != e_xui_wait_data);
    assign fsm_wdf_rdy = (state_r != e_xui_wait_cmd);

    // ready_en_r keeps both readies low until the first edge out of reset.
    assign app_rdy_o     = ready_en_r & ~stall & fsm_rdy;
    assign app_wdf_rdy_o = ready_en_r & ~stall & fsm_wdf_rdy;

    assign cmd_acc   = app_en_i & app_rdy_o;
    assign data_acc  = app_wdf_wren_i & app_wdf_rdy_o;
    assign cmd_is_wr = (app_cmd_i == e_xui_cmd_wr);
    assign cmd_is_rd = (app_cmd_i == e_xui_cmd_rd);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_xui_idle;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            ready_en_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch_addr) begin
            addr_r <= cmd_idx;
        end
        if (latch_data) begin
            wdata_r <= app_wdf_data_i;
            wmask_r <= app_wdf_mask_i;
        end
    end

    // Pairs write commands with write data; at most one RAM access per cycle.
    always_comb begin
        state_n    = state_r;
        ram_v      = 1'b0;
        ram_w      = 1'b0;
        ram_addr   = cmd_idx;
        ram_wdata  = app_wdf_data_i;
        ram_wmask  = ~app_wdf_mask_i;
        latch_addr = 1'b0;
        latch_data = 1'b0;
        case (state_r)
            e_xui_idle: begin
                if (cmd_acc & cmd_is_wr & data_acc) begin
                    ram_v = 1'b1;
                    ram_w = 1'b1;
                end else if (cmd_acc & cmd_is_wr) begin
                    latch_addr = 1'b1;
                    state_n    = e_xui_wait_data;
                end else begin
                    if (cmd_acc & cmd_is_rd) begin
                        ram_v = 1'b1;
                    end
                    if (data_acc) begin
                        latch_data = 1'b1;
                        state_n    = e_xui_wait_cmd;
                    end
                end
            end
            e_xui_wait_data: begin
                if (data_acc) begin
                    ram_v    = 1'b1;
                    ram_w    = 1'b1;
                    ram_addr = addr_r;
                    state_n  = e_xui_idle;
                end
            end
            e_xui_wait_cmd: begin
                if (cmd_acc & cmd_is_wr) begin
                    ram_v     = 1'b1;
                    ram_w     = 1'b1;
                    ram_wdata = wdata_r;
                    ram_wmask = ~wmask_r;
                    state_n   = e_xui_idle;
                end else if (cmd_acc & cmd_is_rd) begin
                    ram_v = 1'b1;
                end
            end
            default: state_n = e_xui_idle;
        endcase
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .width_p(block_width_p),
        .els_p  (els_p)
    ) ram (
        .clk_i       (clk_i),
        .reset_i     (~reset_n_i),
        .data_i      (ram_wdata),
        .addr_i      (ram_addr),
        .v_i         (ram_v),
        .write_mask_i(ram_wmask),
        .w_i         (ram_w),
        .data_o      (ram_rdata)
    );

    bp_me_xui_rd_pipe #(
        .width_p     (block_width_p),
        .rd_latency_p(rd_latency_p)
    ) rd_pipe (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .rd_v_i    (ram_v & ~ram_w),
        .ram_data_i(ram_rdata),
        .v_o       (app_rd_data_valid_o),
        .data_o    (app_rd_data_o)
    );

    assign app_rd_data_end_o = app_rd_data_valid_o;

endmodule

// File: tb/tb_bp_me_xui_ram_responder.sv
// Self-checking bench for bp_me_xui_ram_responder: directed scenarios with
// literal expectations plus randomized traffic against a transaction-level model.
module tb_bp_me_xui_ram_responder;

    localparam int PW  = 32;
    localparam int BW  = 512;
    localparam int ELS = 1024;
    localparam int LAT = 4;
    localparam int MW  = BW/8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [PW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0;
    logic          app_rdy;
    logic          app_wdf_wren = 1'b0;
    logic [BW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_wdf_mask = '0;
    logic          app_wdf_end = 1'b0;
    logic          app_wdf_rdy;
    logic          app_rd_data_valid;
    logic [BW-1:0] app_rd_data;
    logic          app_rd_data_end;

    bp_me_xui_ram_responder #(
        .paddr_width_p(PW), .block_width_p(BW), .els_p(ELS), .rd_latency_p(LAT),
        .refresh_period_p(512), .refresh_len_p(8)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .app_addr_i         (app_addr),
        .app_cmd_i          (app_cmd),
        .app_en_i           (app_en),
        .app_rdy_o          (app_rdy),
        .app_wdf_wren_i     (app_wdf_wren),
        .app_wdf_data_i     (app_wdf_data),
        .app_wdf_mask_i     (app_wdf_mask),
        .app_wdf_end_i      (app_wdf_end),
        .app_wdf_rdy_o      (app_wdf_rdy),
        .app_rd_data_valid_o(app_rd_data_valid),
        .app_rd_data_o      (app_rd_data),
        .app_rd_data_end_o  (app_rd_data_end)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [BW-1:0] data;
        bit            known;
    } rd_t;

    // Transaction-level model: memory image, pending unpaired write half, return queue.
    logic [BW-1:0] model_mem [ELS];
    bit            model_known [ELS];
    rd_t           rd_q [$];
    bit            pend_cmd, pend_data, reset_done;
    int            pend_idx;
    logic [BW-1:0] pend_wdata;
    logic [MW-1:0] pend_wmask;
    logic [BW-1:0] last_data = '0;
    bit            last_known = 1'b1;
    int            edge_cnt = 0;
    logic [BW-1:0] rx_q [$];
    int            n_checks = 0;
    int            n_fail = 0;

    bit m_rdy, m_wdf, m_cacc, m_dacc, m_valid;
    int m_idx;

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int addr2idx(input logic [PW-1:0] a);
        return int'(a[6 +: 10]);
    endfunction

    task automatic model_write(input int idx, input logic [BW-1:0] d, input logic [MW-1:0] m);
        for (int b = 0; b < MW; b++) begin
            if (!m[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
        if (m == '0) model_known[idx] = 1'b1;
    endtask

    // Model update: every accepted command / data beat, using the model's own readies.
    initial forever begin
        @(posedge clk);
        edge_cnt++;
        if (reset_n) begin
            m_rdy  = reset_done && !pend_cmd;
            m_wdf  = reset_done && !pend_data;
            m_cacc = app_en && m_rdy;
            m_dacc = app_wdf_wren && m_wdf;
            m_idx  = addr2idx(app_addr);
            if (m_cacc && app_cmd == 3'b001)
                rd_q.push_back('{due: edge_cnt + LAT - 1, data: model_mem[m_idx], known: model_known[m_idx]});
            if (m_cacc && app_cmd == 3'b000) begin
                if (m_dacc) begin
                    model_write(m_idx, app_wdf_data, app_wdf_mask);
                end else if (pend_data) begin
                    model_write(m_idx, pend_wdata, pend_wmask);
                    pend_data = 1'b0;
                end else begin
                    pend_cmd = 1'b1;
                    pend_idx = m_idx;
                end
            end else if (m_dacc) begin
                if (pend_cmd) begin
                    model_write(pend_idx, app_wdf_data, app_wdf_mask);
                    pend_cmd = 1'b0;
                end else begin
                    pend_data  = 1'b1;
                    pend_wdata = app_wdf_data;
                    pend_wmask = app_wdf_mask;
                end
            end
            reset_done = 1'b1;
        end
    end

    // Compare process: checks every output on every falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            rd_q.delete();
            pend_cmd   = 1'b0;
            pend_data  = 1'b0;
            reset_done = 1'b0;
            last_data  = '0;
            last_known = 1'b1;
            checkOutput("reset_rdy", BW'(app_rdy), '0);
            checkOutput("reset_wdf_rdy", BW'(app_wdf_rdy), '0);
            checkOutput("reset_valid", BW'(app_rd_data_valid), '0);
            checkOutput("reset_end", BW'(app_rd_data_end), '0);
            checkOutput("reset_data", app_rd_data, '0);
        end else begin
            m_valid = (rd_q.size() > 0) && (rd_q[0].due == edge_cnt);
            if (m_valid) begin
                last_data  = rd_q[0].data;
                last_known = rd_q[0].known;
                void'(rd_q.pop_front());
            end
            checkOutput("app_rdy", BW'(app_rdy), BW'(reset_done && !pend_cmd));
            checkOutput("app_wdf_rdy", BW'(app_wdf_rdy), BW'(reset_done && !pend_data));
            checkOutput("rd_valid", BW'(app_rd_data_valid), BW'(m_valid));
            checkOutput("rd_end", BW'(app_rd_data_end), BW'(m_valid));
            if (last_known) checkOutput("rd_data", app_rd_data, last_data);
            if (app_rd_data_valid) rx_q.push_back(app_rd_data);
        end
    end

    task automatic applyStimulus(input logic en, input logic [2:0] cmd, input logic [PW-1:0] addr,
                                 input logic wren, input logic [BW-1:0] data, input logic [MW-1:0] mask);
        app_en       = en;
        app_cmd      = cmd;
        app_addr     = addr;
        app_wdf_wren = wren;
        app_wdf_end  = wren;
        app_wdf_data = data;
        app_wdf_mask = mask;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'b000, '0, 1'b0, '0, '0);
    endtask

    task automatic checkRx(input string name, input int i, input logic [BW-1:0] exp);
        logic [BW-1:0] act;
        act = (i < rx_q.size()) ? rx_q[i] : '0;
        checkOutput(name, act, exp);
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    logic [7:0]    b8;
    logic [BW-1:0] rdat;
    logic [MW-1:0] rmask;
    int            rsel, ridx;

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        checkOutput("rdy_low_after_deassert", BW'(app_rdy), '0);
        idle(1);
        checkOutput("rdy_rise", BW'(app_rdy), BW'(1));
        checkOutput("wdf_rdy_rise", BW'(app_wdf_rdy), BW'(1));

        // Same-cycle write then read at exact latency
        applyStimulus(1'b1, 3'b000, 32'h40, 1'b1, {64{8'hA5}}, '0);
        checkOutput("model_pin_a5", model_mem[1], {64{8'hA5}});
        rx_q.delete();
        applyStimulus(1'b1, 3'b001, 32'h40, 1'b0, '0, '0);
        idle(2);
        checkOutput("t1_not_early", BW'(app_rd_data_valid), '0);
        idle(1);
        checkOutput("t1_valid_at_lat", BW'(app_rd_data_valid), BW'(1));
        checkOutput("t1_end_at_lat", BW'(app_rd_data_end), BW'(1));
        checkOutput("t1_data", app_rd_data, {64{8'hA5}});
        idle(1);
        checkOutput("t1_one_cycle", BW'(app_rd_data_valid), '0);

        // Command first, data three cycles later
        applyStimulus(1'b1, 3'b000, 32'h80, 1'b0, '0, '0);
        checkOutput("t2_rdy_low1", BW'(app_rdy), '0);
        checkOutput("t2_wdf_high", BW'(app_wdf_rdy), BW'(1));
        idle(1);
        checkOutput("t2_rdy_low2", BW'(app_rdy), '0);
        idle(1);
        checkOutput("t2_rdy_low3", BW'(app_rdy), '0);
        applyStimulus(1'b0, 3'b000, '0, 1'b1, {64{8'h3C}}, '0);
        checkOutput("t2_rdy_back", BW'(app_rdy), BW'(1));
        rx_q.delete();
        applyStimulus(1'b1, 3'b001, 32'h80, 1'b0, '0, '0);
        idle(6);
        checkRx("t2_read", 0, {64{8'h3C}});

        // Data first, read in between, then command
        rx_q.delete();
        applyStimulus(1'b0, 3'b000, '0, 1'b1, {64{8'h77}}, '0);
        checkOutput("t3_wdf_low1", BW'(app_wdf_rdy), '0);
        checkOutput("t3_rdy_high", BW'(app_rdy), BW'(1));
        applyStimulus(1'b1, 3'b001, 32'h80, 1'b0, '0, '0);
        checkOutput("t3_wdf_low2", BW'(app_wdf_rdy), '0);
        applyStimulus(1'b1, 3'b000, 32'h80, 1'b0, '0, '0);
        checkOutput("t3_wdf_back", BW'(app_wdf_rdy), BW'(1));
        applyStimulus(1'b1, 3'b001, 32'h80, 1'b0, '0, '0);
        idle(6);
        checkOutput("t3_count", BW'(rx_q.size()), BW'(2));
        checkRx("t3_old", 0, {64{8'h3C}});
        checkRx("t3_new", 1, {64{8'h77}});

        // Byte mask: low four bytes kept
        applyStimulus(1'b1, 3'b000, 32'hC0, 1'b1, {BW{1'b1}}, '0);
        applyStimulus(1'b1, 3'b000, 32'hC0, 1'b1, '0, MW'(64'h0F));
        rx_q.delete();
        applyStimulus(1'b1, 3'b001, 32'hC0, 1'b0, '0, '0);
        idle(6);
        checkRx("t4_mask", 0, {{60{8'h00}}, 32'hFFFF_FFFF});

        // Back-to-back reads, last one aliases 0x40
        for (int i = 0; i < 7; i++) begin
            b8 = 8'(8'h11 * (i + 1));
            applyStimulus(1'b1, 3'b000, PW'(32'h200 + 32'h40 * i), 1'b1, {64{b8}}, '0);
        end
        rx_q.delete();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 3'b001, PW'(32'h200 + 32'h40 * i), 1'b0, '0, '0);
        applyStimulus(1'b1, 3'b001, PW'(32'h40 + ELS * 64), 1'b0, '0, '0);
        idle(6);
        checkOutput("t5_count", BW'(rx_q.size()), BW'(8));
        for (int i = 0; i < 7; i++) begin
            b8 = 8'(8'h11 * (i + 1));
            checkRx($sformatf("t5_order%0d", i), i, {64{b8}});
        end
        checkRx("t5_alias", 7, {64{8'hA5}});

        // Reset with two reads in flight
        rx_q.delete();
        applyStimulus(1'b1, 3'b001, 32'h40, 1'b0, '0, '0);
        applyStimulus(1'b1, 3'b001, 32'h80, 1'b0, '0, '0);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rdy_in_reset", BW'(app_rdy), '0);
        idle(2);
        reset_n = 1'b1;
        idle(8);
        checkOutput("t6_no_stale_valid", BW'(rx_q.size()), '0);
        checkOutput("t6_rdy_after", BW'(app_rdy), BW'(1));

        // Randomized traffic over blocks 16..31 with aliased high bits
        for (int i = 16; i < 32; i++) applyStimulus(1'b1, 3'b000, PW'(i * 64), 1'b1, rand_blk(), '0);
        for (int c = 0; c < 3000; c++) begin
            rsel  = $urandom_range(0, 9);
            ridx  = $urandom_range(16, 31);
            rdat  = rand_blk();
            rmask = ($urandom_range(0, 1) == 0) ? '0 : MW'({$urandom, $urandom});
            applyStimulus(1'($urandom_range(0, 1)),
                          (rsel < 4) ? 3'b000 : (rsel < 9) ? 3'b001 : 3'($urandom_range(2, 7)),
                          ($urandom & 32'hFFFF_0000) | PW'(ridx * 64) | PW'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), rdat, rmask);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_xui_ram_responder.md
# bp_me_xui_ram_responder

Responder side of the Xilinx user interface (XUI/MIG "app_*" port): accepts single-beat read and write commands from a CCE-to-XUI adapter and services them from a local synchronous RAM. Read data is returned after a fixed pipeline latency. It stands in for the MIG and DRAM in simulation and FPGA-less bring-up of the BlackParrot memory path.

## Interface
Parameters:
- paddr_width_p, "inv", app address width (matches the adapter's paddr)
- block_width_p, "inv", data beat width in bits (equals cce_block_width_p); multiple of 8
- els_p, 1024, RAM depth in blocks; power of two
- rd_latency_p, 4, cycles from read accept to app_rd_data_valid_o; ≥1
- refresh_period_p, 512, cycles between refresh stalls (only with macro)
- refresh_len_p, 8, stall length in cycles (only with macro); < refresh_period_p

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- app_addr_i  in  paddr_width_p  byte address
- app_cmd_i  in  3  000 write, 001 read
- app_en_i  in  1  command valid
- app_rdy_o  out  1  command ready
- app_wdf_wren_i  in  1  write data valid
- app_wdf_data_i  in  block_width_p  write data
- app_wdf_mask_i  in  block_width_p/8  byte mask, 1 = byte NOT written
- app_wdf_end_i  in  1  last beat (always 1 with wren; ignored otherwise)
- app_wdf_rdy_o  out  1  write data ready
- app_rd_data_valid_o  out  1  read data valid
- app_rd_data_o  out  block_width_p  read data
- app_rd_data_end_o  out  1  last read beat (= valid)

## Operation
- Command accepted when app_en_i & app_rdy_o; write data accepted when app_wdf_wren_i & app_wdf_rdy_o.
- RAM index = app_addr_i[lg(block_width_p/8) +: lg(els_p)]; higher address bits ignored (wrap).
- Write pairing FSM:
  - IDLE: rdy_o = wdf_rdy_o = 1. Write cmd + data same cycle → commit, stay IDLE. Write cmd alone → latch addr, WAIT_DATA. Data alone → latch data/mask, WAIT_CMD. Read cmd → issue read (a same-cycle data beat with a read goes to WAIT_CMD).
  - WAIT_DATA: app_rdy_o = 0, app_wdf_rdy_o = 1; data arrives → commit, IDLE.
  - WAIT_CMD: app_rdy_o = 1, app_wdf_rdy_o = 0; write cmd → commit buffered data, IDLE; read cmd → issue read, stay WAIT_CMD.
- Commit = masked byte write at end of the commit cycle; read accepted on a later cycle sees it.
- Reads: no back-pressure on the read-return path; all reads return in order, one per cycle max.
- Unknown app_cmd_i accepted and dropped (no state change, no response).
- Reset: FSM → IDLE, read pipeline cleared; RAM contents not reset. Reads in flight at reset are lost.

## Timing
- Reset values: app_rdy_o 0, app_wdf_rdy_o 0, app_rd_data_valid_o 0, app_rd_data_o 0, app_rd_data_end_o 0; readies rise first cycle after reset_n_i deasserts.
- Read accepted cycle T → app_rd_data_valid_o high exactly cycle T+rd_latency_p, one cycle; data held until next valid.
- Back-to-back reads each cycle → back-to-back valids, same order.
- Write commit cycle T; read accepted T+1 returns new data.
- Readies are functions of registered state only (no comb path from app_en_i/wren_i).

## Configuration
- BP_XUI_REFRESH_STALL_EN defined: free-running counter mod refresh_period_p; for the first refresh_len_p counts of each period app_rdy_o and app_wdf_rdy_o are forced 0; read pipeline keeps draining. Counter restarts at reset.
- Undefined: no counter, readies governed only by FSM.

## Structure
- Package bp_me_xui_pkg: enum bp_xui_cmd_e (e_xui_cmd_wr = 3'b000, e_xui_cmd_rd = 3'b001), FSM state enum.
- Sub-module bp_me_xui_rd_pipe: rd_latency_p-stage valid/data shift register after a 1-cycle RAM read.
- RAM: bsg_mem_1rw_sync_mask_write_byte instance.

## Test plan
- Write addr 0x40 data 0xA5.. mask 0, same-cycle wren; read 0x40 at T → valid at T+4 with 0xA5...
- Write cmd at T, data at T+3 → app_rdy_o low T+1..T+3, commit T+3; read returns data.
- Data before cmd: wren at T, cmd at T+2 with read in between at T+1 → read returns old data, app_wdf_rdy_o low T+1..T+2.
- Mask 0x0F on all-ones word with zero data → low 4 bytes preserved, rest zero.
- 8 back-to-back reads to distinct addresses → 8 consecutive valids, order preserved; address 0x40 + els_p·64 aliases 0x40.
- Reset asserted with 2 reads in flight → no valids after reset; with macro, readies low exactly refresh_len_p cycles every refresh_period_p.
